// File: rtl/rvfi_mem_serializer.sv
// rtl/rvfi_mem_serializer.sv - reorders multi-channel RVFI memory retirements into one in-order stream
//
// Purpose: buffers the memory-relevant RVFI fields of each retired instruction
// in a slot indexed by the low bits of rvfi_order, then emits at most one record
// per cycle in strictly increasing order. Orders outside the accept window
// [expect_ord, expect_ord+DEPTH) mod 256 and duplicate orders are dropped. Each
// of these cases sets a sticky flag.
//
// Optional feature macro: RISCV_FORMAL_SERIALIZE_ASSERT_EN adds immediate
// assertions on the error flags and on fill.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rvfi_*                NRET-channel RVFI retirement bundle (flattened)
//   out_valid, out_*      registered single-channel record
//   err_window, err_dup   sticky error flags
//   fill                  number of occupied slots

`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

module rvfi_mem_serializer #(
   parameter int DEPTH = 8,
   parameter int XLEN  = `RISCV_FORMAL_XLEN,
   parameter int NRET  = `RISCV_FORMAL_NRET
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NRET-1:0]         rvfi_valid,
   input  logic [NRET*8-1:0]       rvfi_order,
   input  logic [NRET*32-1:0]      rvfi_insn,
   input  logic [NRET-1:0]         rvfi_trap,
   input  logic [NRET*XLEN-1:0]    rvfi_mem_addr,
   input  logic [NRET*XLEN/8-1:0]  rvfi_mem_rmask,
   input  logic [NRET*XLEN/8-1:0]  rvfi_mem_wmask,
   input  logic [NRET*XLEN-1:0]    rvfi_mem_rdata,
   input  logic [NRET*XLEN-1:0]    rvfi_mem_wdata,
   output logic                    out_valid,
   output logic [7:0]              out_order,
   output logic [31:0]             out_insn,
   output logic                    out_trap,
   output logic [XLEN-1:0]         out_mem_addr,
   output logic [XLEN/8-1:0]       out_mem_rmask,
   output logic [XLEN/8-1:0]       out_mem_wmask,
   output logic [XLEN-1:0]         out_mem_rdata,
   output logic [XLEN-1:0]         out_mem_wdata,
   output logic                    err_window,
   output logic                    err_dup,
   output logic [$clog2(DEPTH):0]  fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int MW = XLEN / 8;
   localparam logic [8:0] DEPTH9 = 9'(DEPTH);

   // next order to emit ("expect" is a reserved word)
   logic [7:0]       expect_ord;
   logic [DEPTH-1:0] occ;
   logic [DEPTH-1:0] occ_next;

   logic [31:0]      p_insn  [DEPTH];
   logic             p_trap  [DEPTH];
   logic [XLEN-1:0]  p_addr  [DEPTH];
   logic [MW-1:0]    p_rmask [DEPTH];
   logic [MW-1:0]    p_wmask [DEPTH];
   logic [XLEN-1:0]  p_rdata [DEPTH];
   logic [XLEN-1:0]  p_wdata [DEPTH];

   logic [AW-1:0]    eslot;
   logic             emit;
   logic [NRET-1:0]  wr_en;
   logic             win_hit;
   logic             dup_hit;

   assign eslot = expect_ord[AW-1:0];
   // decided on start-of-cycle occupancy only: no same-cycle bypass
   assign emit  = occ[eslot];

   // Per-channel accept decision in ascending channel order. A lower channel
   // carrying the same order wins, even if it is itself rejected.
   always_comb begin
      logic [7:0] diff;
      logic       dup_lower;
      wr_en   = '0;
      win_hit = 1'b0;
      dup_hit = 1'b0;
      diff    = '0;
      dup_lower = 1'b0;
      for (int c = 0; c < NRET; c++) begin
         if (rvfi_valid[c]) begin
            diff = rvfi_order[c*8 +: 8] - expect_ord;
            dup_lower = 1'b0;
            for (int j = 0; j < c; j++) begin
               if (rvfi_valid[j] && (rvfi_order[j*8 +: 8] == rvfi_order[c*8 +: 8]))
                  dup_lower = 1'b1;
            end
            if ({1'b0, diff} >= DEPTH9)
               win_hit = 1'b1;
            else if (occ[rvfi_order[c*8 +: AW]] || dup_lower)
               dup_hit = 1'b1;
            else
               wr_en[c] = 1'b1;
         end
      end
   end

   // An in-window write never lands on the emitting slot unless order==expect,
   // and that case is already a duplicate, so clear-then-set is safe.
   always_comb begin
      occ_next = occ;
      if (emit)
         occ_next[eslot] = 1'b0;
      for (int c = 0; c < NRET; c++) begin
         if (wr_en[c])
            occ_next[rvfi_order[c*8 +: AW]] = 1'b1;
      end
   end

   always_comb begin
      fill = '0;
      for (int i = 0; i < DEPTH; i++)
         fill = fill + {{AW{1'b0}}, occ[i]};
   end

   // payload needs no reset: occ gates every read
   always_ff @(posedge clk) begin
      for (int c = 0; c < NRET; c++) begin
         if (wr_en[c]) begin
            p_insn [rvfi_order[c*8 +: AW]] <= rvfi_insn[c*32 +: 32];
            p_trap [rvfi_order[c*8 +: AW]] <= rvfi_trap[c];
            p_addr [rvfi_order[c*8 +: AW]] <= rvfi_mem_addr[c*XLEN +: XLEN];
            p_rmask[rvfi_order[c*8 +: AW]] <= rvfi_mem_rmask[c*MW +: MW];
            p_wmask[rvfi_order[c*8 +: AW]] <= rvfi_mem_wmask[c*MW +: MW];
            p_rdata[rvfi_order[c*8 +: AW]] <= rvfi_mem_rdata[c*XLEN +: XLEN];
            p_wdata[rvfi_order[c*8 +: AW]] <= rvfi_mem_wdata[c*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         expect_ord    <= '0;
         occ           <= '0;
         out_valid     <= 1'b0;
         out_order     <= '0;
         out_insn      <= '0;
         out_trap      <= 1'b0;
         out_mem_addr  <= '0;
         out_mem_rmask <= '0;
         out_mem_wmask <= '0;
         out_mem_rdata <= '0;
         out_mem_wdata <= '0;
         err_window    <= 1'b0;
         err_dup       <= 1'b0;
      end else begin
         occ       <= occ_next;
         out_valid <= emit;
         if (emit) begin
            out_order     <= expect_ord;
            out_insn      <= p_insn[eslot];
            out_trap      <= p_trap[eslot];
            out_mem_addr  <= p_addr[eslot];
            out_mem_rmask <= p_rmask[eslot];
            out_mem_wmask <= p_wmask[eslot];
            out_mem_rdata <= p_rdata[eslot];
            out_mem_wdata <= p_wdata[eslot];
            expect_ord    <= expect_ord + 8'd1;
         end
         if (win_hit)
            err_window <= 1'b1;
         if (dup_hit)
            err_dup <= 1'b1;
`ifdef RISCV_FORMAL_SERIALIZE_ASSERT_EN
         assert (!err_window && !err_dup);
         assert ({{(31-AW){1'b0}}, fill} <= DEPTH);
`endif
      end
   end

endmodule

// File: tb/tb_rvfi_mem_serializer.sv
// tb/tb_rvfi_mem_serializer.sv - directed self-checking bench for rvfi_mem_serializer
module tb_rvfi_mem_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rvfi_valid;
   logic [15:0] rvfi_order;
   logic [63:0] rvfi_insn;
   logic [1:0]  rvfi_trap;
   logic [63:0] rvfi_mem_addr;
   logic [7:0]  rvfi_mem_rmask;
   logic [7:0]  rvfi_mem_wmask;
   logic [63:0] rvfi_mem_rdata;
   logic [63:0] rvfi_mem_wdata;
   logic        out_valid;
   logic [7:0]  out_order;
   logic [31:0] out_insn;
   logic        out_trap;
   logic [31:0] out_mem_addr;
   logic [3:0]  out_mem_rmask;
   logic [3:0]  out_mem_wmask;
   logic [31:0] out_mem_rdata;
   logic [31:0] out_mem_wdata;
   logic        err_window;
   logic        err_dup;
   logic [3:0]  fill;

   int checks = 0;
   int errors = 0;

   rvfi_mem_serializer #(.DEPTH(8), .XLEN(32), .NRET(2)) dut (
      .clk(clk), .reset(reset),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
      .rvfi_trap(rvfi_trap), .rvfi_mem_addr(rvfi_mem_addr),
      .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
      .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
      .out_valid(out_valid), .out_order(out_order), .out_insn(out_insn),
      .out_trap(out_trap), .out_mem_addr(out_mem_addr),
      .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask),
      .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
      .err_window(err_window), .err_dup(err_dup), .fill(fill)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = '0;
      rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
      rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
   endtask

   task automatic put(input int ch, input logic [7:0] ord, input logic [31:0] wd);
      rvfi_valid[ch]             = 1'b1;
      rvfi_order[ch*8 +: 8]      = ord;
      rvfi_insn[ch*32 +: 32]     = 32'h1300_0000 | {24'h0, ord};
      rvfi_trap[ch]              = ord[0];
      rvfi_mem_addr[ch*32 +: 32] = 32'h100 + {22'h0, ord, 2'b00};
      rvfi_mem_rmask[ch*4 +: 4]  = 4'h0;
      rvfi_mem_wmask[ch*4 +: 4]  = 4'hf;
      rvfi_mem_rdata[ch*32 +: 32] = 32'hD000_0000 | {24'h0, ord};
      rvfi_mem_wdata[ch*32 +: 32] = wd;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] ord);
      check_val({tag, "_valid"}, {31'h0, out_valid}, {31'h0, v});
      if (v)
         check_val({tag, "_order"}, {24'h0, out_order}, {24'h0, ord});
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      tick();
      tick();
      // reset state
      check_val("rst_valid", {31'h0, out_valid}, 32'h0);
      check_val("rst_fill", {28'h0, fill}, 32'h0);
      check_val("rst_errw", {31'h0, err_window}, 32'h0);
      check_val("rst_errd", {31'h0, err_dup}, 32'h0);
      check_val("rst_wdata", out_mem_wdata, 32'h0);
      reset = 1'b0;

      // two orders swapped across channels
      put(0, 8'd1, 32'hA001);
      put(1, 8'd0, 32'hA000);
      tick();
      clear_in();
      check_val("sw_fill0", {28'h0, fill}, 32'd2);
      check_val("sw_v0", {31'h0, out_valid}, 32'h0);
      tick();
      expect_out("sw1", 1'b1, 8'd0);
      check_val("sw_fill1", {28'h0, fill}, 32'd1);
      check_val("sw_wd0", out_mem_wdata, 32'hA000);
      check_val("sw_trap0", {31'h0, out_trap}, 32'h0);
      tick();
      expect_out("sw2", 1'b1, 8'd1);
      check_val("sw_fill2", {28'h0, fill}, 32'd0);
      check_val("sw_insn1", out_insn, 32'h1300_0001);
      check_val("sw_trap1", {31'h0, out_trap}, 32'h1);
      check_val("sw_addr1", out_mem_addr, 32'h104);
      check_val("sw_rdata1", out_mem_rdata, 32'hD000_0001);
      check_val("sw_rmask1", {28'h0, out_mem_rmask}, 32'h0);
      check_val("sw_wmask1", {28'h0, out_mem_wmask}, 32'hf);
      tick();
      expect_out("sw3", 1'b0, 8'd0);
      check_val("sw_wd_hold", out_mem_wdata, 32'hA001);

      // 2..5 early, then 0..1: six back-to-back emissions
      do_reset();
      put(0, 8'd2, 32'hB002); put(1, 8'd3, 32'hB003); tick(); clear_in();
      put(0, 8'd4, 32'hB004); put(1, 8'd5, 32'hB005); tick(); clear_in();
      tick();
      tick();
      expect_out("ooo_idle", 1'b0, 8'd0);
      put(0, 8'd0, 32'hB000); put(1, 8'd1, 32'hB001); tick(); clear_in();
      check_val("ooo_fill", {28'h0, fill}, 32'd6);
      expect_out("ooo_w", 1'b0, 8'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         expect_out("ooo_run", 1'b1, 8'(k));
      end
      tick();
      expect_out("ooo_end", 1'b0, 8'd0);
      check_val("ooo_errw", {31'h0, err_window}, 32'h0);
      check_val("ooo_errd", {31'h0, err_dup}, 32'h0);

      // expect = 6: order 14 outside window, 13 inside
      put(0, 8'd14, 32'hC00E); put(1, 8'd13, 32'hC00D); tick(); clear_in();
      check_val("win_err", {31'h0, err_window}, 32'h1);
      check_val("win_fill", {28'h0, fill}, 32'd1);
      put(0, 8'd6, 32'hC006); put(1, 8'd7, 32'hC007); tick(); clear_in();
      expect_out("win_a", 1'b0, 8'd0);
      put(0, 8'd8, 32'hC008); put(1, 8'd9, 32'hC009); tick(); clear_in();
      expect_out("win_b", 1'b1, 8'd6);
      put(0, 8'd10, 32'hC00A); put(1, 8'd11, 32'hC00B); tick(); clear_in();
      expect_out("win_c", 1'b1, 8'd7);
      put(0, 8'd12, 32'hC00C); tick(); clear_in();
      expect_out("win_d", 1'b1, 8'd8);
      for (int k = 9; k <= 13; k++) begin
         tick();
         expect_out("win_run", 1'b1, 8'(k));
      end
      check_val("win_wd13", out_mem_wdata, 32'hC00D);
      tick();
      expect_out("win_no14", 1'b0, 8'd0);
      check_val("win_sticky", {31'h0, err_window}, 32'h1);
      check_val("win_nodup", {31'h0, err_dup}, 32'h0);

      // same order on both channels: ch0 data kept
      do_reset();
      put(0, 8'd3, 32'h1111_0003); put(1, 8'd3, 32'h2222_0003); tick(); clear_in();
      check_val("dup_err", {31'h0, err_dup}, 32'h1);
      check_val("dup_fill", {28'h0, fill}, 32'd1);
      put(0, 8'd0, 32'h0); put(1, 8'd1, 32'h0); tick(); clear_in();
      put(0, 8'd2, 32'h0); tick(); clear_in();
      expect_out("dup_o0", 1'b1, 8'd0);
      tick();
      expect_out("dup_o1", 1'b1, 8'd1);
      tick();
      expect_out("dup_o2", 1'b1, 8'd2);
      tick();
      expect_out("dup_o3", 1'b1, 8'd3);
      check_val("dup_wd", out_mem_wdata, 32'h1111_0003);
      check_val("dup_noerrw", {31'h0, err_window}, 32'h0);

      // 0..259 streamed one per cycle: wrap 255 -> 0 with no gap
      do_reset();
      for (int k = 0; k < 260; k++) begin
         put(0, 8'(k), 32'(k));
         tick();
         clear_in();
         if (k >= 251)
            expect_out("wrap", 1'b1, 8'(k - 1));
      end
      tick();
      expect_out("wrap_last", 1'b1, 8'd3);
      check_val("wrap_errw", {31'h0, err_window}, 32'h0);
      check_val("wrap_errd", {31'h0, err_dup}, 32'h0);

      // reset with three records buffered (expect = 4)
      put(0, 8'd5, 32'h5); put(1, 8'd6, 32'h6); tick(); clear_in();
      put(0, 8'd7, 32'h7); put(1, 8'd200, 32'hC8); tick(); clear_in();
      check_val("mr_fill", {28'h0, fill}, 32'd3);
      check_val("mr_errw", {31'h0, err_window}, 32'h1);
      reset = 1'b1;
      put(0, 8'd4, 32'h4);
      tick();
      check_val("mr_fill0", {28'h0, fill}, 32'd0);
      check_val("mr_valid", {31'h0, out_valid}, 32'h0);
      check_val("mr_errw0", {31'h0, err_window}, 32'h0);
      check_val("mr_order0", {24'h0, out_order}, 32'h0);
      clear_in();
      reset = 1'b0;
      put(0, 8'd0, 32'hE000); tick(); clear_in();
      expect_out("mr_a", 1'b0, 8'd0);
      check_val("mr_fill1", {28'h0, fill}, 32'd1);
      tick();
      expect_out("mr_b", 1'b1, 8'd0);
      check_val("mr_wd", out_mem_wdata, 32'hE000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvfi_mem_serializer.md
# rvfi_mem_serializer

In-order serializer placed directly upstream of the data-memory consistency checker. It accepts the `RISCV_FORMAL_NRET`-channel RVFI retirement bundle, buffers the memory-relevant fields of each retired instruction by `rvfi_order`, and emits them as a single-channel stream in strictly increasing order, one instruction per cycle at most. The checker then sees memory accesses in program order even when the core retires several instructions per cycle on arbitrary channels. Window violations and duplicate orders raise sticky error flags.

## Interface

- `DEPTH`, 8: buffer entries; power of two, 2..128. Slot index is `order[log2(DEPTH)-1:0]`.
- Widths come from `RISCV_FORMAL_XLEN` (X) and `RISCV_FORMAL_NRET` (N).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rvfi_valid`  in  N  per-channel retire strobe.
- `rvfi_order`  in  N*8  per-channel instruction order.
- `rvfi_insn`  in  N*32  per-channel instruction word.
- `rvfi_trap`  in  N  per-channel trap flag.
- `rvfi_mem_addr`, `rvfi_mem_rdata`, `rvfi_mem_wdata`  in  N*X each  per-channel memory fields.
- `rvfi_mem_rmask`, `rvfi_mem_wmask`  in  N*X/8 each  per-channel byte masks.
- `out_valid`  out  1  serialized record valid this cycle.
- `out_order`, `out_insn`, `out_trap`, `out_mem_addr`, `out_mem_rmask`, `out_mem_wmask`, `out_mem_rdata`, `out_mem_wdata`  out  same widths as one channel of the matching input.
- `err_window`  out  1  sticky: order outside the accept window.
- `err_dup`  out  1  sticky: order already buffered or repeated within one cycle.
- `fill`  out  log2(DEPTH)+1  occupied slot count.

## Operation

- State:
  - `expect`: 8-bit next order to emit.
  - Per-slot `occ` bit and payload.
  - Registered output record.
  - Two sticky error bits.
- Accept window:
  - An order `o` is in window iff `(o - expect) mod 256 < DEPTH`.
  - Arithmetic is 8-bit and wraps: `expect` 255 -> 0 is legal, and 254..(254+DEPTH-1) mod 256 is a contiguous window.
- Write, per valid channel, evaluated in ascending channel index:
  - Out of window: drop the record and set `err_window`.
  - Slot already occupied, or same order on a lower-index channel this cycle: drop the record and set `err_dup`. The first writer's data is kept.
  - Otherwise: store the payload and set `occ`.
- Emit, each cycle:
  - If `occ[expect]` was set at the start of the cycle: register that slot's payload onto the `out_*` ports, assert `out_valid`, clear `occ`, and increment `expect`.
  - Otherwise `out_valid` = 0. `out_*` data ports hold their previous values.
- No bypass:
  - A record arriving with `order == expect` is written this cycle and emitted next cycle.
  - Emission and write never target the same slot in one cycle. A write to slot `expect mod DEPTH` other than `order == expect` is out of window by construction.
- `fill` = number of set `occ` bits after the cycle's update.
- No backpressure. Sustained input above 1/cycle must stay within `DEPTH`; exceeding it yields `err_window`.

## Timing

- Reset (synchronous, when `reset` is high at the edge):
  - `expect` = 0, all `occ` = 0, `fill` = 0.
  - `out_valid` = 0 and all `out_*` = 0.
  - `err_window` = `err_dup` = 0.
- Inputs presented with `reset` high are ignored.
- Reset mid-operation discards all buffered records. The first post-reset record must carry order 0.
- Latency:
  - Minimum 1 cycle from input edge to `out_valid`.
  - A record waits additional cycles while any lower order is missing.
- Throughput: exactly 1 record/cycle while consecutive orders are buffered.
- Error flags rise on the edge after the offending input and stay set until reset.

## Configuration

- `RISCV_FORMAL_SERIALIZE_ASSERT_EN`:
  - Defined: adds immediate `assert(!err_window && !err_dup)` in the clocked block and `assert(fill <= DEPTH)`, so formal runs fail at the offending step.
  - Undefined: no assertions; the error flags are the only indication. Functional behaviour is otherwise identical.

## Test plan

- N=2, DEPTH=8. Cycle 0: ch0 order 1, ch1 order 0 -> `out_valid` with order 0 at cycle 1, order 1 at cycle 2, then `out_valid` = 0; `fill` 2,1,0.
- Orders 2..5 delivered 4 cycles before orders 0..1 -> once order 0 arrives, six consecutive `out_valid` cycles with orders 0..5; no errors.
- `expect` = 6 with DEPTH=8; order 14 arrives -> `err_window` = 1 next cycle; record never emitted. Order 13 is accepted.
- Order 3 on ch0 and ch1 in the same cycle, different `mem_wdata` -> `err_dup` = 1; emitted order 3 carries the ch0 `wdata`.
- Run orders 250..255 then 0..3 continuously -> output order wraps 255 -> 0 with no gap and no error.
- Reset asserted while `fill` = 3 -> next cycle `fill` = 0, `out_valid` = 0, flags clear. Then order 0 -> `out_valid` one cycle later.
